// File: rtl/pry2idx_seq.sv
//============================================================================
// Module      : pry2idx_seq
// Description : Sequential priority-to-index converter. Captures a bit
//               vector over a valid/ready port and emits the binary index
//               of every set bit, LSB first, one per cycle on a valid/ready
//               stream with a last flag.
//               Optional macro PRY2IDX_SEQ_CNT_EN adds m_cnt, the number of
//               set bits still pending (current beat included).
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module pry2idx_seq #(
    parameter  int WIDTH     = 32,
    localparam int WIDTH_LOG = $clog2(WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 s_vld,
    output logic                 s_rdy,
    input  logic [WIDTH-1:0]     s_pry,
    output logic                 m_vld,
    input  logic                 m_rdy,
    output logic [WIDTH_LOG-1:0] m_idx,
    output logic                 m_lst,
`ifdef PRY2IDX_SEQ_CNT_EN
    output logic [WIDTH_LOG:0]   m_cnt,
`endif
    output logic                 busy
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_SCAN = 1'b1
    } state_t;

    localparam logic [WIDTH-1:0] c_ONE = WIDTH'(1);

    state_t                 r_state;
    logic [WIDTH-1:0]       r_mask;

    logic                   w_scan;
    logic                   w_hs;
    logic                   w_lst;
    logic                   w_load;
    logic [WIDTH-1:0]       w_mask_nxt;
    logic [WIDTH_LOG-1:0]   w_idx;

    assign w_scan     = (r_state == S_SCAN);
    assign w_hs       = w_scan && m_rdy;
    // Clearing the lowest set bit; also the "more than one bit" test.
    assign w_mask_nxt = r_mask & (r_mask - c_ONE);
    assign w_lst      = (r_mask != '0) && (w_mask_nxt == '0);
    // A zero vector is accepted but never loaded, so it vanishes silently.
    assign w_load     = s_vld && s_rdy && (s_pry != '0);

    // Rightmost set bit of the mask; scanning downward lets bit 0 win.
    always_comb begin
        w_idx = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (r_mask[i]) begin
                w_idx = WIDTH_LOG'(i);
            end
        end
    end

    assign m_vld = w_scan;
    assign m_idx = w_idx;
    assign m_lst = w_lst;
    assign busy  = w_scan;
    // Ready on the final beat too, so the next vector follows without a bubble.
    assign s_rdy = (r_state == S_IDLE) || (w_hs && w_lst);

    // Scan FSM and mask: load on non-zero accept, else strip one bit per beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_mask  <= '0;
        end else if (w_load) begin
            r_state <= S_SCAN;
            r_mask  <= s_pry;
        end else if (w_hs) begin
            r_mask <= w_mask_nxt;
            if (w_lst) begin
                r_state <= S_IDLE;
            end
        end
    end

`ifdef PRY2IDX_SEQ_CNT_EN
    logic [WIDTH_LOG:0] r_cnt;
    logic [WIDTH_LOG:0] w_pop;

    // Population count of the incoming vector, used only when it is loaded.
    always_comb begin
        w_pop = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_pop = w_pop + {{WIDTH_LOG{1'b0}}, s_pry[i]};
        end
    end

    // Remaining-beat counter tracks the mask: reload on accept, count down per beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (w_load) begin
            r_cnt <= w_pop;
        end else if (w_hs) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign m_cnt = r_cnt;
`endif

endmodule

`default_nettype wire
